// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_odd,
    output logic                 tx_serial,
    output logic                 tx_empty,
    output logic                 bit_tick,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_q;
    logic                 serial_q;
    logic                 empty_q;
    logic                 done_q;
    logic                 bit_last;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign bit_last = (cnt_q == CNT_LAST);
    assign cnt_d    = bit_last ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            stop_q   <= 1'b0;
            serial_q <= 1'b1;
            empty_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par_q    <= (^tx_data) ^ parity_odd;
`endif
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        stop_q   <= 1'b0;
                        serial_q <= 1'b0;
                        empty_q  <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        idx_q    <= '0;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            serial_q <= par_q;
                            state_q  <= S_PARITY;
`else
                            serial_q <= 1'b1;
                            state_q  <= S_STOP;
`endif
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_last) begin
                        serial_q <= 1'b1;
                        state_q  <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_last) begin
                        if (stop_q == STOP_LAST) begin
                            // Frame complete: idle again, ready for a same-cycle restart request
                            empty_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_serial = serial_q;
    assign tx_empty  = empty_q;
    assign tx_done   = done_q;
    assign bit_tick  = (state_q != S_IDLE) && bit_last;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one DUT with 1 stop bit, one with 2, both 16 clocks/bit, 8 data bits.
`timescale 1ns/1ps
module tb_uart_tx_param;

    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_odd = 1'b0;
    logic       ser1, emp1, tick1, done1;
    logic       ser2, emp2, tick2, done2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clock(clock), .reset(reset), .tx_start(start1), .tx_data(tx_data),
        .parity_odd(parity_odd), .tx_serial(ser1), .tx_empty(emp1),
        .bit_tick(tick1), .tx_done(done1)
    );

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .tx_start(start2), .tx_data(tx_data),
        .parity_odd(parity_odd), .tx_serial(ser2), .tx_empty(emp2),
        .bit_tick(tick2), .tx_done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level per bit position; positions past the frame read as idle-high.
    function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic podd);
        logic [15:0] v;
        v      = '1;
        v[0]   = 1'b0;
        v[8:1] = d;
        if (P == 1) v[9] = (^d) ^ podd;
        return v;
    endfunction

    task automatic run_frame(input int sel, input logic [7:0] d, input logic podd,
                             input bit hold, input bit disturb, input logic [7:0] nd,
                             input string tag, output logic [15:0] obs);
        int f, ticks, bad_line, bad_tick, bad_done, bad_empty;
        logic [15:0] expv;
        logic ser, tk, dn, em;
        f = 1 + 8 + P + ((sel == 0) ? 1 : 2);
        expv = exp_frame(d, podd);
        ticks = 0; bad_line = 0; bad_tick = 0; bad_done = 0; bad_empty = 0;
        obs = '1;
        tx_data = d;
        parity_odd = podd;
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clock); #1;
        if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
        for (int c = 0; c < f * C; c++) begin
            ser = (sel == 0) ? ser1 : ser2;
            tk  = (sel == 0) ? tick1 : tick2;
            dn  = (sel == 0) ? done1 : done2;
            em  = (sel == 0) ? emp1 : emp2;
            if (ser !== expv[c / C]) bad_line++;
            if (c % C == C / 2) obs[c / C] = ser;
            if (tk === 1'b1) begin
                ticks++;
                if (c % C != C - 1) bad_tick++;
            end else if (c % C == C - 1) begin
                bad_tick++;
            end
            if (dn !== 1'b0) bad_done++;
            if (em !== 1'b0) bad_empty++;
            if (disturb && c == 50) begin
                if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
                tx_data = ~d;
                parity_odd = ~podd;
            end
            if (disturb && c == 52) begin start1 = 1'b0; start2 = 1'b0; end
            if (hold && c == 60) tx_data = nd;
            @(posedge clock); #1;
        end
        check({tag, "_line_errs"}, bad_line, 0);
        check({tag, "_tick_count"}, ticks, f);
        check({tag, "_tick_place"}, bad_tick, 0);
        check({tag, "_early_done"}, bad_done, 0);
        check({tag, "_busy_empty"}, bad_empty, 0);
        check({tag, "_done"}, (sel == 0) ? done1 : done2, 1);
        check({tag, "_empty_end"}, (sel == 0) ? emp1 : emp2, 1);
        check({tag, "_serial_end"}, (sel == 0) ? ser1 : ser2, 1);
        check({tag, "_tick_end"}, (sel == 0) ? tick1 : tick2, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] obs;
        int dcount, hcount;

        // Reset held for 3 cycles, then released idle
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("rst_serial", ser1, 1);
            check("rst_empty", emp1, 1);
            check("rst_done", done1, 0);
            check("rst_tick", tick1, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("idle_serial", ser1, 1);
            check("idle_empty", emp1, 1);
            check("idle_done", done1, 0);
            check("idle_tick", tick1, 0);
            check("idle2_serial", ser2, 1);
        end

        // 8'h55 frame: alternating line pattern
        run_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, "f55", obs);
`ifdef UART_TX_PARITY_EN
        check("f55_pattern", {21'd0, obs[10:0]}, {21'd0, 11'b10010101010});
`else
        check("f55_pattern", {22'd0, obs[9:0]}, {22'd0, 10'b1010101010});
`endif
        @(posedge clock); #1;
        check("f55_done_once", done1, 0);

`ifdef UART_TX_PARITY_EN
        run_frame(0, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, "par_even", obs);
        check("par_even_bit", obs[9], 1);
        run_frame(0, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, "par_odd", obs);
        check("par_odd_bit", obs[9], 0);
`endif

        // Back-to-back: tx_start held, data changed mid-frame to the next word
        run_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h3C, "b2b_a5", obs);
        check("b2b_a5_data", obs[8:1], 8'hA5);
        run_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, "b2b_3c", obs);
        check("b2b_3c_data", obs[8:1], 8'h3C);

        // Reset 50 cycles into an 8'hFF frame
        tx_data = 8'hFF;
        start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (50) begin @(posedge clock); #1; end
        check("abort_busy", emp1, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_serial", ser1, 1);
        check("abort_empty", emp1, 1);
        check("abort_done", done1, 0);
        reset = 1'b0;
        dcount = 0; hcount = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (done1 !== 1'b0) dcount++;
            if (ser1 !== 1'b1 || emp1 !== 1'b1) hcount++;
        end
        check("abort_no_done", dcount, 0);
        check("abort_idle", hcount, 0);
        run_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00, "after_abort", obs);
        check("after_abort_data", obs[8:1], 8'hC3);

        // Two stop bits, 8'h00
        run_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "stop2", obs);
        check("stop2_data", obs[8:1], 8'h00);
        check("stop2_stopbits", {30'd0, obs[10+P], obs[9+P]}, 32'd3);
        check("stop2_dut1_idle", emp1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next generation of the fixed 8N1 bit-timing generator. It accepts a parallel word through a start/empty handshake and serialises it LSB-first on `tx_serial` with a start bit, optional parity and 1 or 2 stop bits. Every bit lasts exactly `CLKS_PER_BIT` clocks. It sits between the host-side register/FIFO logic and the board TX pin, and exports bit-boundary and frame-done strobes for the status logic.

## Interface
- `CLKS_PER_BIT`, 1302, clocks per bit period (50 MHz / 38400 baud); must be ≥ 2.
- `DATA_BITS`, 8, payload bits per frame; legal range 5–9.
- `STOP_BITS`, 1, number of stop bits; 1 or 2.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `tx_start`  in  1  request to send; sampled only while `tx_empty`=1.
- `tx_data`  in  DATA_BITS  payload; latched on acceptance.
- `parity_odd`  in  1  0 = even parity, 1 = odd; latched on acceptance; ignored without `UART_TX_PARITY_EN`.
- `tx_serial`  out  1  serial line; idles high.
- `tx_empty`  out  1  transmitter idle and able to accept.
- `bit_tick`  out  1  one-cycle pulse in the last clock of each bit period.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx_serial`=1 and `tx_empty`=1.
  - When `tx_start`=1 at an edge, latch `tx_data` and `parity_odd`, clear the bit counter and go to START.
- START: drive 0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - Drive `shift[0]` and shift right at each bit boundary.
  - After bit index DATA_BITS−1, go to PARITY if it is compiled in, otherwise go to STOP.
- PARITY: drive XOR of the latched data, XOR `parity_odd`, for one bit period, then go to STOP.
- STOP: drive 1 for `STOP_BITS` bit periods, then go to IDLE.
- Bit counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..CLKS_PER_BIT−1 and wraps to 0 at the boundary.
  - `bit_tick`=1 exactly when the counter equals CLKS_PER_BIT−1 outside IDLE.
- `tx_start` while busy is ignored; it is not queued.
- Changes on `tx_data` and `parity_odd` after acceptance have no effect on the frame in flight.
- Bits per frame: F = 1 + DATA_BITS + P + STOP_BITS, where P = 1 with the macro and 0 without.
- Reset at any time, including mid-frame, forces IDLE at the next edge. No `tx_done` is issued for the aborted frame.

## Timing
- Reset values:
  - `tx_serial`=1, `tx_empty`=1, `bit_tick`=0, `tx_done`=0.
  - State IDLE, counters 0, shift register 0.
- Acceptance edge E0: from E0 onward `tx_serial`=0 and `tx_empty`=0. This is 1 cycle of latency from `tx_start`.
- Bit k occupies cycles E0 + k·CLKS_PER_BIT through E0 + (k+1)·CLKS_PER_BIT − 1.
- At edge E0 + F·CLKS_PER_BIT the block returns to IDLE:
  - `tx_empty` rises to 1.
  - `tx_done` pulses high for that one cycle.
  - `tx_serial` stays 1.
- Back-to-back: `tx_start`=1 during the `tx_done` cycle is accepted. The minimum idle gap between frames is therefore 1 clock.
- `bit_tick` pulses F times per frame; the last pulse is in the cycle before `tx_done`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is present and F includes the parity bit.
  - `parity_odd` selects even or odd parity.
- Not defined:
  - PARITY state and parity logic are compiled out and F = 1 + DATA_BITS + STOP_BITS.
  - The `parity_odd` port remains but is unused.

## Test plan
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8.
- Reset held 3 cycles, then released with `tx_start`=0 → `tx_serial`=1, `tx_empty`=1, `tx_done`=0, `bit_tick`=0 on every cycle.
- No parity, 8'h55 accepted at E0 → line pattern 0,1,0,1,0,1,0,1,0,1, each 16 cycles → `tx_done` in the cycle after E0+160 → exactly 10 `bit_tick` pulses.
- `UART_TX_PARITY_EN`, 8'h07:
  - `parity_odd`=0 → parity bit 1.
  - `parity_odd`=1 → parity bit 0.
  - Frame is 176 cycles in both cases.
- `tx_start` held high with 8'hA5 then 8'h3C → the 8'h3C start bit begins at the edge ending the `tx_done` cycle → pulses of `tx_start` mid-frame do not disturb the frame.
- Reset asserted 50 cycles into an 8'hFF frame → next cycle `tx_serial`=1 and `tx_empty`=1 → no `tx_done` → a new frame is accepted normally.
- STOP_BITS=2, no parity, 8'h00 → stop level high for 32 cycles → `tx_done` after E0+176.
